// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO and its storage array.
package fifo_pkg;

  // Integer type used for address and pointer widths.
  typedef int ptr_w_t;

  // Number of address bits needed to index a DEPTH-entry array.
  function automatic ptr_w_t addr_w(input ptr_w_t depth);
    return ptr_w_t'($clog2(depth));
  endfunction

  // Pointer width: address bits plus one wrap bit.
  function automatic ptr_w_t ptr_w(input ptr_w_t depth);
    return addr_w(depth) + 32'sd1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write, registered read port,
// optional clearing of the array on reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int RESET_MEM  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [addr_w(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic                       re,
  input  logic [addr_w(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]      rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  // Next array contents and next read word.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d[waddr] = mem_q[waddr];
    end
    if (re) begin
      rdata_d = mem_q[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Array register; only cleared on reset when RESET_MEM is set.
  always_ff @(posedge clk) begin
    if (rst && (RESET_MEM != 0)) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Registered read word, zeroed on reset, held when no read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO: pointers, occupancy count, level flags, sticky
// error flags and flush around the fifo_ram storage array.
module sync_fifo_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int RESET_MEM  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow,
  output logic                        underflow,
  input  logic                        err_clr
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  if ((AE_LEVEL < 0) || (AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > DEPTH) ||
      (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_params
    $error("sync_fifo_buf: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_valid_q, rd_valid_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             full_s, empty_s;
  logic             wr_acc_s, rd_acc_s, wr_rej_s, rd_rej_s;
  logic             ram_we_s, ram_re_s;

  assign full_s  = (count_q == CNT_W'(DEPTH));
  assign empty_s = (count_q == {CNT_W{1'b0}});

  // Acceptance, pointer/count update, read-valid and sticky errors.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wr_acc_s   = wr_en & ~full_s & ~flush;
    rd_acc_s   = rd_en & ~empty_s & ~flush;
    wr_rej_s   = wr_en & full_s & ~flush;
    rd_rej_s   = rd_en & empty_s & ~flush;
    rd_valid_d = rd_acc_s;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    // A new error in the same cycle as err_clr wins.
    if (wr_rej_s) begin
      ovf_d = 1'b1;
    end else if (err_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (rd_rej_s) begin
      udf_d = 1'b1;
    end else if (err_clr) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Reset blocks array writes and read-data updates.
  assign ram_we_s = wr_acc_s & ~rst;
  assign ram_re_s = rd_acc_s & ~rst;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .RESET_MEM  (RESET_MEM)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we_s),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (wr_data),
    .re    (ram_re_s),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  assign rd_valid     = rd_valid_q;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_buf.sv
// Randomised + directed bench for sync_fifo_buf with a queue-based
// reference model and a scoreboard for popped words.
module tb_sync_fifo_buf;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty;
  logic [3:0]    count;
  logic          overflow, underflow;

  always #5 clk = ~clk;

  sync_fifo_buf #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE),
    .RESET_MEM  (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: FIFO contents as a plain queue.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;
  bit            m_valid = 1'b0;
  logic [DW-1:0] m_last = '0;
  bit            mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Apply one clock of stimulus and advance the model on that edge.
  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r,
                     input bit f = 1'b0, input bit ec = 1'b0, input bit rs = 1'b0);
    int n;
    bit wa, ra;
    wr_en = w; wr_data = d; rd_en = r; flush = f; err_clr = ec; rst = rs;
    @(posedge clk);
    n = mq.size();
    if (rs) begin
      mq.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0; m_last = '0;
    end else if (f) begin
      mq.delete(); m_valid = 1'b0;
      if (ec) begin m_ovf = 1'b0; m_udf = 1'b0; end
    end else begin
      wa = w && (n < DEPTH);
      ra = r && (n > 0);
      if (ra) begin
        m_last = mq.pop_front();
        exp_q.push_back(m_last);
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (wa) mq.push_back(d);
      m_ovf = (w && !wa) ? 1'b1 : (ec ? 1'b0 : m_ovf);
      m_udf = (r && !ra) ? 1'b1 : (ec ? 1'b0 : m_udf);
    end
    #1;
  endtask

  // Monitor: compare flags every cycle, pop the scoreboard on rd_valid.
  always @(negedge clk) begin
    if (mon_en) begin
      check("count", 32'(count), 32'(mq.size()));
      check("empty", 32'(empty), 32'(mq.size() == 0));
      check("full", 32'(full), 32'(mq.size() == DEPTH));
      check("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
      check("almost_empty", 32'(almost_empty), 32'(mq.size() <= AE));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("underflow", 32'(underflow), 32'(m_udf));
      check("rd_valid", 32'(rd_valid), 32'(m_valid));
      check("rd_data_hold", 32'(rd_data), 32'(m_last));
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underrun", 32'd1, 32'd0);
        end else begin
          check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] v;
    int ph;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    cyc(1'b0, '0, 1'b0);

    // Fill with 0x11..0x88 then drain in order.
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 8'(i * 17), 1'b0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);

    // Overflow on full, then clear it.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b1, 8'hAA, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Drain, then simultaneous read/write on empty.
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1);
    cyc(1'b1, 8'h5C, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Half-full streaming across pointer wrap.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'(8'h80 + i), 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);

    // Flush at count=5 with a concurrent write.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1);
    cyc(1'b1, 8'h3C, 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);

    // Read followed by reset.
    cyc(1'b1, 8'h77, 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0);

    // Randomised traffic with phases biased toward filling or draining.
    for (int i = 0; i < 3000; i++) begin
      ph = (i / 64) % 3;
      v  = 8'($urandom);
      cyc(($urandom_range(0, 9) < (ph == 0 ? 8 : (ph == 1 ? 2 : 5))),
          v,
          ($urandom_range(0, 9) < (ph == 0 ? 2 : (ph == 1 ? 8 : 5))),
          ($urandom_range(0, 59) == 0),
          1'b0,
          ($urandom_range(0, 299) == 0));
      if ($urandom_range(0, 19) == 0) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    end
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
